lzy_vending_ctrl: RTL and testbench
===================================

LZY_VENDING_CTRL -- requirements
Module: lzy_vending_ctrl

Interface
REQ-001 SHALL provide parameter PRICE, default 5, item price in half-yuan units.
REQ-002 SHALL provide parameter CW, default 4, width of the credit register; PRICE+1 < 2^CW SHALL hold.
REQ-003 SHALL provide the ports below:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Coin  in  2  bit0 = 0.5-yuan coin (1 unit), bit1 = 1-yuan coin (2 units), one-cycle pulses.
- Cancel  in  1  refund request, one-cycle pulse.
- Vend  out  1  dispense item, one-cycle pulse.
- Chg_pulse  out  1  one pulse per returned 0.5-yuan unit.
- Coin_rej  out  1  coin sampled this cycle was not credited; registered, one cycle later.
- Busy  out  1  high while in S_VEND or S_CHG.
- Credit  out  CW  current credit in units, registered.

Function
REQ-004 SHALL implement a Moore FSM with states S_IDLE (Credit=0), S_ACC (0<Credit<PRICE), S_VEND and S_CHG.
REQ-005 In S_IDLE/S_ACC, a valid coin (Coin=01 or 10) SHALL add its value to Credit at the sampling edge.
REQ-006 If the new credit is >= PRICE, the FSM SHALL enter S_VEND; otherwise it SHALL enter S_ACC.
REQ-007 Coin=11 SHALL not be credited; Coin_rej SHALL pulse for exactly one cycle after the sampling edge.
REQ-008 A coin sampled in S_VEND or S_CHG SHALL not be credited and SHALL raise Coin_rej.
REQ-009 S_VEND SHALL last exactly one cycle with Vend=1, and PRICE SHALL be subtracted from Credit on exit.
REQ-010 S_VEND SHALL go to S_CHG if the remaining credit is >0, else to S_IDLE.
REQ-011 In S_CHG, Chg_pulse SHALL be 1 every cycle and Credit SHALL decrement by 1 per cycle; the FSM SHALL exit to S_IDLE on the edge at which Credit reaches 0.
REQ-012 The number of Chg_pulse cycles SHALL equal the credit remaining after the vend, or the refunded credit.
REQ-013 Latency: a coin completing the price at edge N SHALL give Vend=1 during cycle N..N+1; change pulses SHALL start at the next cycle.
REQ-014 Vend and Chg_pulse SHALL never both be 1 in the same cycle.
REQ-015 Busy SHALL be high exactly while the state is S_VEND or S_CHG.
REQ-016 Credit SHALL never exceed PRICE+1; there SHALL be no wrap-around of the credit register.

Reset
REQ-017 Reset=0 SHALL force S_IDLE, Credit=0 and Vend=Chg_pulse=Coin_rej=Busy=0 immediately, without waiting for Clk.
REQ-018 Reset asserted during S_VEND or S_CHG SHALL abort the transaction; pending change SHALL be discarded and no further pulses SHALL be issued.
REQ-019 After reset release, the first Clk edge SHALL sample inputs normally.

Configuration
REQ-020 When macro LZY_VM_CANCEL_EN is defined:
- Cancel in S_ACC SHALL enter S_CHG, refunding all credit with no Vend.
- Cancel in S_IDLE, S_VEND or S_CHG SHALL have no effect.
- Cancel together with a coin SHALL take priority; the coin SHALL be rejected with Coin_rej.
REQ-021 When LZY_VM_CANCEL_EN is undefined, the Cancel port SHALL remain present but be ignored.

Verification
REQ-022 PRICE=5, coins 10,10,01 on consecutive cycles -> Credit 2,4,5; one Vend pulse; zero Chg_pulse; return to S_IDLE.
REQ-023 PRICE=5, coins 10,10,10 -> Credit 2,4,6; Vend; Credit 1; one Chg_pulse; then S_IDLE.
REQ-024 Coin=11 in S_IDLE -> Credit stays 0 and Coin_rej=1 for one cycle. Coin=01 during S_CHG -> Coin_rej=1 and the Chg_pulse count is unchanged.
REQ-025 With LZY_VM_CANCEL_EN, credit 3 then Cancel -> three Chg_pulse cycles, no Vend, Credit 0. Without the macro, the same stimulus -> Credit remains 3.
REQ-026 Reset=0 mid-S_CHG with 1 unit pending -> all outputs 0 asynchronously; no Chg_pulse after release.

Source files
------------

// File: rtl/lzy_vending_ctrl.sv
// lzy_vending_ctrl -- coin-operated vending controller (Moore FSM).
//
// Accepts 0.5-yuan (1 unit) and 1-yuan (2 unit) coins, vends one item
// once the credit reaches PRICE, then pays back any surplus one unit per
// cycle. A refund path (Cancel) is compiled in only when the macro
// LZY_VM_CANCEL_EN is defined. Otherwise the Cancel port is present but
// has no effect.
//
// Parameters:
//   PRICE  item price in half-yuan units (default 5)
//   CW     credit register width; PRICE+1 must fit (PRICE+1 < 2**CW)
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous active-low reset
//   Coin[1:0]  in   01 = 1 unit, 10 = 2 units, 11 = invalid (one-cycle pulses)
//   Cancel     in   refund request pulse (LZY_VM_CANCEL_EN builds only)
//   Vend       out  dispense pulse, high for the single S_VEND cycle
//   Chg_pulse  out  one cycle high per returned unit
//   Coin_rej   out  registered: the coin sampled at the last edge was not credited
//   Busy       out  high in S_VEND or S_CHG
//   Credit     out  current credit in units (registered)
module lzy_vending_ctrl #(
  parameter int PRICE = 5,
  parameter int CW    = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [1:0]    Coin,
  input  logic          Cancel,
  output logic          Vend,
  output logic          Chg_pulse,
  output logic          Coin_rej,
  output logic          Busy,
  output logic [CW-1:0] Credit
);

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_VEND = 2'd2,
    S_CHG  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   credit_nxt;
  logic            rej_nxt;
  logic            coin_valid;
  logic            coin_any;
  logic            cancel_hit;

  // Unit value of a valid coin. Only called for 01/10.
  function automatic logic [CW-1:0] coin_value(input logic [1:0] c);
    coin_value = (c == 2'b10) ? CW'(2) : CW'(1);
  endfunction

  assign coin_valid = (Coin == 2'b01) || (Coin == 2'b10);
  assign coin_any   = (Coin != 2'b00);

`ifdef LZY_VM_CANCEL_EN
  // Refund is only meaningful with credit outstanding and no transaction running.
  assign cancel_hit = Cancel && (state == S_ACC);
`else
  logic unused_cancel;
  assign unused_cancel = Cancel;
  assign cancel_hit    = 1'b0;
`endif

  // State / credit / reject registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      Credit   <= '0;
      Coin_rej <= 1'b0;
    end else begin
      state    <= state_nxt;
      Credit   <= credit_nxt;
      Coin_rej <= rej_nxt;
    end
  end

  // Next-state and credit update
  always_comb begin
    state_nxt  = state;
    credit_nxt = Credit;
    rej_nxt    = 1'b0;
    unique case (state)
      S_IDLE, S_ACC: begin
        if (cancel_hit) begin
          // Refund takes priority; a coin arriving with Cancel is bounced.
          state_nxt = S_CHG;
          rej_nxt   = coin_any;
        end else if (coin_valid) begin
          // Credit was below PRICE here, so the sum is at most PRICE+1.
          credit_nxt = Credit + coin_value(Coin);
          state_nxt  = (credit_nxt >= PRICE_C) ? S_VEND : S_ACC;
        end else begin
          rej_nxt = (Coin == 2'b11);
        end
      end
      S_VEND: begin
        credit_nxt = Credit - PRICE_C;
        state_nxt  = (credit_nxt != '0) ? S_CHG : S_IDLE;
        rej_nxt    = coin_any;
      end
      S_CHG: begin
        // Leave on the edge where the last unit is paid out.
        credit_nxt = Credit - CW'(1);
        state_nxt  = (credit_nxt == '0) ? S_IDLE : S_CHG;
        rej_nxt    = coin_any;
      end
      default: begin
        state_nxt  = S_IDLE;
        credit_nxt = '0;
      end
    endcase
  end

  // Moore outputs decoded from the state register, so reset clears them at once.
  assign Vend      = (state == S_VEND);
  assign Chg_pulse = (state == S_CHG);
  assign Busy      = (state == S_VEND) || (state == S_CHG);

endmodule

// File: tb/tb_lzy_vending_ctrl.sv
module tb_lzy_vending_ctrl;

  localparam int PRICE = 5;
  localparam int CW    = 4;
`ifdef LZY_VM_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  localparam int EV_VEND = 1;
  localparam int EV_CHG  = 2;

  logic          Clk;
  logic          Reset;
  logic [1:0]    Coin;
  logic          Cancel;
  logic          Vend;
  logic          Chg_pulse;
  logic          Coin_rej;
  logic          Busy;
  logic [CW-1:0] Credit;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: credit as a plain integer plus a schedule of future
  // output cycles (one vend cycle, then one cycle per unit of change).
  int m_credit;
  int m_rej;
  int sched[$];

  lzy_vending_ctrl #(.PRICE(PRICE), .CW(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Coin(Coin), .Cancel(Cancel),
    .Vend(Vend), .Chg_pulse(Chg_pulse), .Coin_rej(Coin_rej),
    .Busy(Busy), .Credit(Credit)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int ev;
    ev = (sched.size() > 0) ? sched[0] : 0;
    check({tag, ".Credit"},    int'(Credit),    m_credit);
    check({tag, ".Vend"},      int'(Vend),      (ev == EV_VEND) ? 1 : 0);
    check({tag, ".Chg_pulse"}, int'(Chg_pulse), (ev == EV_CHG) ? 1 : 0);
    check({tag, ".Busy"},      int'(Busy),      (sched.size() > 0) ? 1 : 0);
    check({tag, ".Coin_rej"},  int'(Coin_rej),  m_rej);
  endtask

  task automatic mdl_reset();
    m_credit = 0;
    m_rej    = 0;
    sched.delete();
  endtask

  task automatic mdl_edge(input logic [1:0] c, input logic k);
    int ev;
    m_rej = 0;
    if (sched.size() > 0) begin
      ev = sched.pop_front();
      if (ev == EV_VEND) m_credit -= PRICE;
      else               m_credit -= 1;
      m_rej = (c != 2'b00) ? 1 : 0;
    end else if (CANCEL_EN && k && m_credit > 0) begin
      repeat (m_credit) sched.push_back(EV_CHG);
      m_rej = (c != 2'b00) ? 1 : 0;
    end else if (c == 2'b01 || c == 2'b10) begin
      m_credit += (c == 2'b10) ? 2 : 1;
      if (m_credit >= PRICE) begin
        sched.push_back(EV_VEND);
        repeat (m_credit - PRICE) sched.push_back(EV_CHG);
      end
    end else begin
      m_rej = (c == 2'b11) ? 1 : 0;
    end
  endtask

  task automatic step(input logic [1:0] c, input logic k, input string tag);
    Coin   = c;
    Cancel = k;
    @(posedge Clk);
    #1;
    mdl_edge(c, k);
    Coin   = 2'b00;
    Cancel = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b0;
    mdl_reset();
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    logic [1:0] rc;
    logic       rk;
    int         r;

    Reset  = 1'b0;
    Coin   = 2'b00;
    Cancel = 1'b0;
    mdl_reset();
    #1;
    check_all("reset_initial");
    @(negedge Clk);
    Reset = 1'b1;

    // Exact price: 2+2+1, one vend, no change
    step(2'b10, 1'b0, "exact_c1");
    step(2'b10, 1'b0, "exact_c2");
    step(2'b01, 1'b0, "exact_vend");
    step(2'b00, 1'b0, "exact_idle");
    step(2'b00, 1'b0, "exact_idle2");

    // Overpay: 2+2+2, vend then one change pulse
    step(2'b10, 1'b0, "over_c1");
    step(2'b10, 1'b0, "over_c2");
    step(2'b10, 1'b0, "over_vend");
    step(2'b00, 1'b0, "over_chg");
    step(2'b00, 1'b0, "over_idle");

    // Invalid coin in idle
    step(2'b11, 1'b0, "inv_coin");
    step(2'b00, 1'b0, "inv_after");

    // Coins during vend and during change are bounced
    step(2'b10, 1'b0, "busy_c1");
    step(2'b10, 1'b0, "busy_c2");
    step(2'b10, 1'b0, "busy_vend");
    step(2'b10, 1'b0, "busy_coin_in_vend");
    step(2'b01, 1'b0, "busy_coin_in_chg");
    step(2'b00, 1'b0, "busy_idle");

    // Cancel with credit 3 (refund only when the feature is built in)
    step(2'b10, 1'b0, "cancel_c1");
    step(2'b01, 1'b0, "cancel_c2");
    step(2'b00, 1'b1, "cancel_req");
    step(2'b00, 1'b0, "cancel_p2");
    step(2'b00, 1'b0, "cancel_p3");
    step(2'b00, 1'b0, "cancel_end");
    do_reset();

    // Cancel in idle does nothing; cancel with a coin bounces the coin
    step(2'b00, 1'b1, "cancel_idle");
    step(2'b01, 1'b0, "cancel_coin_c1");
    step(2'b10, 1'b1, "cancel_with_coin");
    do_reset();

    // Asynchronous reset in the middle of change payout
    step(2'b10, 1'b0, "rst_c1");
    step(2'b10, 1'b0, "rst_c2");
    step(2'b10, 1'b0, "rst_vend");
    step(2'b00, 1'b0, "rst_in_chg");
    #2;
    Reset = 1'b0;
    mdl_reset();
    #1;
    check_all("rst_async");
    @(negedge Clk);
    Reset = 1'b1;
    step(2'b00, 1'b0, "rst_post1");
    step(2'b00, 1'b0, "rst_post2");

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 7));
      rc = (r < 4) ? 2'b00 : 2'(r - 4);
      rk = ($urandom_range(0, 5) == 0);
      step(rc, rk, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
